ofdm_cp_inserter: RTL

OFDM_CP_INSERTER -- requirements
Module: ofdm_cp_inserter

---
 rtl/ofdm_cp_inserter_pkg.sv | 27 ++
 rtl/ofdm_cp_inserter_if.sv | 26 ++
 rtl/cp_bank_ram.sv | 23 ++
 rtl/ofdm_cp_inserter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_cp_inserter_pkg.sv
// Shared types and defaults for the OFDM cyclic-prefix inserter.
package ofdm_cp_pkg;

    localparam int unsigned MIN_LOG2_DEF = 6;
    localparam int unsigned MAX_LOG2_DEF = 12;

    // Config fields sized for the default MAX_LOG2; widen these if MAX_LOG2 grows.
    localparam int unsigned CFG_LOG2_W = $clog2(MAX_LOG2_DEF + 1);
    localparam int unsigned CFG_CP_W   = MAX_LOG2_DEF + 1;

    typedef struct packed {
        logic [CFG_LOG2_W-1:0] log2;
        logic [CFG_CP_W-1:0]   cp;
    } bank_cfg_t;

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_CP,
        R_BODY
    } rd_state_t;

endpackage

// File: rtl/ofdm_cp_inserter_if.sv
// Sample-stream handshake bundle: input symbol stream and output frame stream.
interface ofdm_cp_inserter_if #(
    parameter int unsigned DW = 12
);
    logic          isop;
    logic          ival;
    logic          iready;
    logic [DW-1:0] idata_re;
    logic [DW-1:0] idata_im;
    logic          oval;
    logic          oready;
    logic          osop;
    logic          oeop;
    logic [DW-1:0] odata_re;
    logic [DW-1:0] odata_im;

    modport master (
        output isop, ival, idata_re, idata_im, oready,
        input  iready, oval, osop, oeop, odata_re, odata_im
    );

    modport slave (
        input  isop, ival, idata_re, idata_im, oready,
        output iready, oval, osop, oeop, odata_re, odata_im
    );
endinterface

// File: rtl/cp_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port (rdata holds when not reading).
module cp_bank_ram #(
    parameter int unsigned DW = 12,
    parameter int unsigned AW = 13
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ofdm_cp_inserter.sv
// Ping-pong buffered cyclic-prefix inserter. Optional stats ports under OFDM_CP_STATS_EN.
module ofdm_cp_inserter
    import ofdm_cp_pkg::*;
#(
    parameter int unsigned DW       = 12,
    parameter int unsigned MAX_LOG2 = MAX_LOG2_DEF,
    parameter int unsigned MIN_LOG2 = MIN_LOG2_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(MAX_LOG2+1)-1:0] cfg_log2,
    input  logic [MAX_LOG2:0]             cfg_cp,
    ofdm_cp_inserter_if.slave             bus
`ifdef OFDM_CP_STATS_EN
    ,
    output logic [31:0]                   stat_frames,
    output logic                          stat_err
`endif
);
    localparam int unsigned AW = MAX_LOG2;
    localparam int unsigned LW = $clog2(MAX_LOG2 + 1);
    localparam int unsigned NW = MAX_LOG2 + 1;

    wr_state_t     r_wstate, w_wstate_nxt;
    rd_state_t     r_rstate, w_rstate_nxt;
    logic [AW-1:0] r_widx, w_widx_nxt, w_waddr_idx;
    logic [AW-1:0] r_ridx, w_ridx_nxt, w_cur_idx;
    logic          r_wbank, r_rbank, r_fbank;
    logic [1:0]    r_full, w_full_nxt;
    bank_cfg_t     r_cfg [2];

    logic [LW-1:0] w_log2_c;
    logic [NW-1:0] w_n_new, w_cp_c, w_wn, w_rn, w_rcp;
    logic [AW-1:0] w_rlast;
    logic          w_in, w_we, w_latch, w_fill, w_rel;
    logic          w_cur_v, w_cur_body, w_cur_sop, w_cur_eop, w_issue, w_rtgl;
    logic          w_s1_mv, w_can_issue;
    logic [DW-1:0] w_rdata_re, w_rdata_im;

    logic          r_s1_v, r_s1_sop, r_s1_eop;
    logic          r_oval, r_osop, r_oeop;
    logic [DW-1:0] r_odata_re, r_odata_im;

    always_comb begin
        if (cfg_log2 < LW'(MIN_LOG2))      w_log2_c = LW'(MIN_LOG2);
        else if (cfg_log2 > LW'(MAX_LOG2)) w_log2_c = LW'(MAX_LOG2);
        else                               w_log2_c = cfg_log2;
        w_n_new = NW'(1) << w_log2_c;
        w_cp_c  = (cfg_cp > w_n_new) ? w_n_new : cfg_cp;
    end

    assign bus.iready = ~r_full[r_wbank];
    assign w_in       = bus.ival & ~r_full[r_wbank];
    assign w_wn       = NW'(1) << r_cfg[r_wbank].log2;

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_widx_nxt   = r_widx;
        w_waddr_idx  = r_widx;
        w_we         = 1'b0;
        w_latch      = 1'b0;
        w_fill       = 1'b0;
        if (w_in) begin
            if (bus.isop) begin
                w_we        = 1'b1;
                w_latch     = 1'b1;
                w_waddr_idx = '0;
                if (w_n_new == NW'(1)) begin
                    w_fill       = 1'b1;
                    w_wstate_nxt = W_IDLE;
                    w_widx_nxt   = '0;
                end else begin
                    w_wstate_nxt = W_FILL;
                    w_widx_nxt   = AW'(1);
                end
            end else if (r_wstate == W_FILL) begin
                w_we = 1'b1;
                if ({1'b0, r_widx} == w_wn - NW'(1)) begin
                    w_fill       = 1'b1;
                    w_wstate_nxt = W_IDLE;
                    w_widx_nxt   = '0;
                end else begin
                    w_widx_nxt = r_widx + AW'(1);
                end
            end
        end
    end

    // Output-stage pipeline: stage 1 is the RAM read register, stage 2 the output register.
    assign w_s1_mv     = r_s1_v & (~r_oval | bus.oready);
    assign w_can_issue = ~r_s1_v | w_s1_mv;
    assign w_rel       = r_oval & bus.oready & r_oeop;

    assign w_rn    = NW'(1) << r_cfg[r_rbank].log2;
    assign w_rcp   = NW'(r_cfg[r_rbank].cp);
    assign w_rlast = AW'(w_rn - NW'(1));

    // R_IDLE presents the first frame address directly so reads start the cycle a bank fills.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_ridx_nxt   = r_ridx;
        w_rtgl       = 1'b0;
        w_cur_v      = 1'b0;
        w_cur_body   = 1'b0;
        w_cur_sop    = 1'b0;
        w_cur_idx    = r_ridx;
        case (r_rstate)
            R_IDLE: begin
                w_cur_v    = r_full[r_rbank];
                w_cur_sop  = 1'b1;
                w_cur_body = (w_rcp == '0);
                w_cur_idx  = w_cur_body ? {AW{1'b0}} : AW'(w_rn - w_rcp);
            end
            R_CP:    w_cur_v = 1'b1;
            R_BODY: begin
                w_cur_v    = 1'b1;
                w_cur_body = 1'b1;
            end
            default: ;
        endcase
        w_issue   = w_cur_v & w_can_issue;
        w_cur_eop = w_cur_body & (w_cur_idx == w_rlast);
        if (w_issue) begin
            if (w_cur_eop) begin
                w_rstate_nxt = R_IDLE;
                w_ridx_nxt   = '0;
                w_rtgl       = 1'b1;
            end else if (!w_cur_body && (w_cur_idx == w_rlast)) begin
                w_rstate_nxt = R_BODY;
                w_ridx_nxt   = '0;
            end else begin
                w_rstate_nxt = w_cur_body ? R_BODY : R_CP;
                w_ridx_nxt   = w_cur_idx + AW'(1);
            end
        end
    end

    assign w_full_nxt[0] = (r_full[0] | (w_fill & ~r_wbank)) & ~(w_rel & ~r_fbank);
    assign w_full_nxt[1] = (r_full[1] | (w_fill &  r_wbank)) & ~(w_rel &  r_fbank);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_widx   <= '0;
            r_ridx   <= '0;
            r_wbank  <= 1'b0;
            r_rbank  <= 1'b0;
            r_fbank  <= 1'b0;
            r_full   <= '0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            r_widx   <= w_widx_nxt;
            r_ridx   <= w_ridx_nxt;
            r_full   <= w_full_nxt;
            if (w_fill) r_wbank <= ~r_wbank;
            if (w_rtgl) r_rbank <= ~r_rbank;
            if (w_rel)  r_fbank <= ~r_fbank;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_latch) begin
            r_cfg[r_wbank].log2 <= CFG_LOG2_W'(w_log2_c);
            r_cfg[r_wbank].cp   <= CFG_CP_W'(w_cp_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_oval     <= 1'b0;
            r_osop     <= 1'b0;
            r_oeop     <= 1'b0;
            r_odata_re <= '0;
            r_odata_im <= '0;
        end else begin
            if (w_issue) begin
                r_s1_v   <= 1'b1;
                r_s1_sop <= w_cur_sop;
                r_s1_eop <= w_cur_eop;
            end else if (w_s1_mv) begin
                r_s1_v <= 1'b0;
            end
            if (w_s1_mv) begin
                r_oval     <= 1'b1;
                r_osop     <= r_s1_sop;
                r_oeop     <= r_s1_eop;
                r_odata_re <= w_rdata_re;
                r_odata_im <= w_rdata_im;
            end else if (r_oval && bus.oready) begin
                r_oval <= 1'b0;
                r_osop <= 1'b0;
                r_oeop <= 1'b0;
            end
        end
    end

    assign bus.oval     = r_oval;
    assign bus.osop     = r_osop;
    assign bus.oeop     = r_oeop;
    assign bus.odata_re = r_odata_re;
    assign bus.odata_im = r_odata_im;

    cp_bank_ram #(.DW(DW), .AW(AW + 1)) u_ram_re (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr({r_wbank, w_waddr_idx}),
        .i_wdata(bus.idata_re),
        .i_re   (w_issue),
        .i_raddr({r_rbank, w_cur_idx}),
        .o_rdata(w_rdata_re)
    );

    cp_bank_ram #(.DW(DW), .AW(AW + 1)) u_ram_im (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr({r_wbank, w_waddr_idx}),
        .i_wdata(bus.idata_im),
        .i_re   (w_issue),
        .i_raddr({r_rbank, w_cur_idx}),
        .o_rdata(w_rdata_im)
    );

`ifdef OFDM_CP_STATS_EN
    logic w_clamp, w_err_ev;
    logic [31:0] r_stat_frames;
    logic        r_stat_err;

    assign w_clamp  = (cfg_log2 < LW'(MIN_LOG2)) | (cfg_log2 > LW'(MAX_LOG2)) | (cfg_cp > w_n_new);
    assign w_err_ev = w_in & (bus.isop ? (w_clamp | (r_wstate == W_FILL)) : (r_wstate == W_IDLE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_frames <= '0;
            r_stat_err    <= 1'b0;
        end else begin
            if (w_rel)    r_stat_frames <= r_stat_frames + 32'd1;
            if (w_err_ev) r_stat_err    <= 1'b1;
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_err    = r_stat_err;
`endif
endmodule
